lfsr_health_monitor: RTL and testbench
======================================

LFSR_HEALTH_MONITOR -- requirements
Module: lfsr_health_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the monitored LFSR state.
REQ-002 SHALL have parameter MAX_PERIOD, default 65535: longest period accepted before timeout, also the expected period for period_ok.
REQ-003 SHALL have parameter REP_LIMIT, default 4: number of consecutive identical samples, reference included, that flags a stuck generator.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  begin a measurement; sampled only in IDLE, DONE or FAULT.
REQ-007 in_valid  in  1  state_in carries a new LFSR state this cycle.
REQ-008 state_in  in  WIDTH  LFSR state from the upstream LFSR output.
REQ-009 busy  out  1  high in CAPTURE and RUN.
REQ-010 done  out  1  one-cycle pulse on entry to DONE or FAULT.
REQ-011 period  out  17  samples between the reference and its recurrence; valid in DONE.
REQ-012 period_ok  out  1  high in DONE when period == MAX_PERIOD.
REQ-013 zero_fault, stuck_fault, timeout_fault  out  1 each  sticky fault flags.

Function
REQ-014 A sample is accepted on a rising edge where in_valid=1 and the state is CAPTURE or RUN; in_valid=0 cycles SHALL change nothing.
REQ-015 The FSM SHALL have states IDLE, CAPTURE, RUN, DONE and FAULT.
REQ-016 IDLE: start=1 -> CAPTURE and clear period, period_ok and all fault flags.
REQ-017 CAPTURE, accepted sample nonzero -> store it as ref and as prev, set count=0 and rep=1, go to RUN.
REQ-018 CAPTURE, accepted sample == 0 -> zero_fault=1 and go to FAULT.
REQ-019 RUN, accepted sample s: first set count=count+1, then apply the checks in this priority order.
  (a) s==0 -> zero_fault, FAULT.
  (b) s==prev -> rep=rep+1; if rep reaches REP_LIMIT -> stuck_fault, FAULT; otherwise stay in RUN with no match check.
  (c) s!=prev and s==ref -> period=count, go to DONE.
  (d) count == MAX_PERIOD+1 -> timeout_fault, FAULT.
  (e) otherwise rep=1, prev=s, stay in RUN.
REQ-020 count SHALL be 17 bits and SHALL never wrap; rule (d) fires before any overflow.
REQ-021 period_ok SHALL be registered together with the DONE entry.
REQ-022 All outputs SHALL be registered; done, flags and period appear in the cycle after the edge that accepted the deciding sample.
REQ-023 DONE/FAULT SHALL hold period and flags until start=1, which re-enters CAPTURE exactly as from IDLE.
REQ-024 start SHALL be ignored while busy; rst and start together SHALL be resolved in favour of rst.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, period=0, period_ok=0, all flags=0, count=0, rep=0, ref=0 and prev=0, including mid-RUN.
REQ-026 The first start after rst deasserts SHALL be honoured in the same cycle.

Verification
REQ-027 Drive a maximal 16-bit Fibonacci LFSR (taps 16,14,13,11) from seed 0xACE1, in_valid=1 every cycle -> done pulse after 65535 RUN samples, period=65535, period_ok=1, all flags 0.
REQ-028 Drive ref 0x0001, then 0x0002, 0x0003, 0x0001 -> DONE, period=3, period_ok=0.
REQ-029 Drive ref 0x1234, then 0x5678, 0x0000 -> zero_fault=1, done pulse, period=0; the next start restarts cleanly.
REQ-030 Drive 0x1234 four times (ref plus three repeats) -> stuck_fault=1 after the fourth sample, no DONE; with REP_LIMIT=4, three copies keep RUN.
REQ-031 Build with MAX_PERIOD=15; drive ref 0x0001, then alternate 0x0005/0x0006 -> timeout_fault=1 when count=16.
REQ-032 Insert in_valid=0 gaps during REQ-028 -> identical result; assert rst mid-RUN -> all outputs 0 next cycle; pulse start while busy -> no effect.

Source files
------------

// File: rtl/lfsr_health_monitor.sv
// Checks an upstream LFSR for zero lock-up, stuck output and wrong period.
// Latency: results and done pulse appear one cycle after the deciding sample.
// Backpressure: none; samples are taken only when in_valid=1, and start is ignored while busy.
module lfsr_health_monitor #(
  parameter int WIDTH      = 16,
  parameter int MAX_PERIOD = 65535,
  parameter int REP_LIMIT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] state_in,
  output logic             busy,
  output logic             done,
  output logic [16:0]      period,
  output logic             period_ok,
  output logic             zero_fault,
  output logic             stuck_fault,
  output logic             timeout_fault
);

  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_MAX    = REP_W'(REP_LIMIT);
  localparam logic [16:0]      MAX_P      = 17'(MAX_PERIOD);
  localparam logic [16:0]      TIMEOUT_AT = 17'(MAX_PERIOD + 1);

  typedef enum logic [2:0] {IDLE, CAPTURE, RUN, DONE, FAULT} state_t;

  state_t             state, state_nx;
  logic [16:0]        count, count_nx, cnt_inc;
  logic [REP_W-1:0]   rep, rep_nx, rep_inc;
  logic [WIDTH-1:0]   ref_val, ref_nx, prev, prev_nx;
  logic [16:0]        period_nx;
  logic               busy_nx, done_nx, period_ok_nx;
  logic               zero_nx, stuck_nx, timeout_nx;

  assign cnt_inc = count + 17'd1;
  assign rep_inc = rep + REP_W'(1);

  // Register FSM state, datapath and all outputs; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      rep           <= '0;
      ref_val       <= '0;
      prev          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      period        <= '0;
      period_ok     <= 1'b0;
      zero_fault    <= 1'b0;
      stuck_fault   <= 1'b0;
      timeout_fault <= 1'b0;
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      rep           <= rep_nx;
      ref_val       <= ref_nx;
      prev          <= prev_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      period        <= period_nx;
      period_ok     <= period_ok_nx;
      zero_fault    <= zero_nx;
      stuck_fault   <= stuck_nx;
      timeout_fault <= timeout_nx;
    end
  end

  // Next-state and next-output decode; checks in RUN follow zero > repeat > match > timeout.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    rep_nx       = rep;
    ref_nx       = ref_val;
    prev_nx      = prev;
    period_nx    = period;
    period_ok_nx = period_ok;
    zero_nx      = zero_fault;
    stuck_nx     = stuck_fault;
    timeout_nx   = timeout_fault;
    done_nx      = 1'b0;
    case (state)
      IDLE, DONE, FAULT: begin
        if (start) begin
          state_nx     = CAPTURE;
          period_nx    = '0;
          period_ok_nx = 1'b0;
          zero_nx      = 1'b0;
          stuck_nx     = 1'b0;
          timeout_nx   = 1'b0;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          if (state_in == '0) begin
            zero_nx  = 1'b1;
            state_nx = FAULT;
            done_nx  = 1'b1;
          end else begin
            ref_nx   = state_in;
            prev_nx  = state_in;
            count_nx = '0;
            rep_nx   = REP_W'(1);
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          count_nx = cnt_inc;
          if (state_in == '0) begin
            zero_nx  = 1'b1;
            state_nx = FAULT;
            done_nx  = 1'b1;
          end else if (state_in == prev) begin
            rep_nx = rep_inc;
            if (rep_inc == REP_MAX) begin
              stuck_nx = 1'b1;
              state_nx = FAULT;
              done_nx  = 1'b1;
            end
          end else if (state_in == ref_val) begin
            period_nx    = cnt_inc;
            period_ok_nx = (cnt_inc == MAX_P);
            state_nx     = DONE;
            done_nx      = 1'b1;
          end else if (cnt_inc >= TIMEOUT_AT) begin
            // >= rather than ==: a repeat landing on the boundary sample
            // must not let count slip past the limit and run on to wrap.
            timeout_nx = 1'b1;
            state_nx   = FAULT;
            done_nx    = 1'b1;
          end else begin
            rep_nx  = REP_W'(1);
            prev_nx = state_in;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx == CAPTURE) || (state_nx == RUN);
  end

endmodule

// File: tb/tb_lfsr_health_monitor.sv
// Bench for lfsr_health_monitor: two instances (default and MAX_PERIOD=15) share stimulus.
// A history-based model predicts every output each cycle; literal checks pin key scenarios.
// Stimulus is directed scenarios followed by randomized sample streams.
module tb_lfsr_health_monitor;

  localparam int M_IDLE = 0, M_CAP = 1, M_RUN = 2, M_DONE = 3, M_FAULT = 4;
  localparam int HMAX = 70000;

  logic        clk;
  logic        rst, start, in_valid;
  logic [15:0] state_in;

  logic        busy_o [2];
  logic        done_o [2];
  logic [16:0] period_o [2];
  logic        ok_o [2];
  logic        zf_o [2];
  logic        sf_o [2];
  logic        tf_o [2];

  int total = 0;
  int bad = 0;
  logic armed = 1'b0;

  lfsr_health_monitor dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .state_in(state_in),
    .busy(busy_o[0]), .done(done_o[0]), .period(period_o[0]), .period_ok(ok_o[0]),
    .zero_fault(zf_o[0]), .stuck_fault(sf_o[0]), .timeout_fault(tf_o[0])
  );

  lfsr_health_monitor #(.MAX_PERIOD(15)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .state_in(state_in),
    .busy(busy_o[1]), .done(done_o[1]), .period(period_o[1]), .period_ok(ok_o[1]),
    .zero_fault(zf_o[1]), .stuck_fault(sf_o[1]), .timeout_fault(tf_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          mode [2];
  int          hlen [2];
  logic [15:0] hist [0:1][0:HMAX-1];
  logic        e_busy [2], e_done [2], e_ok [2], e_zf [2], e_sf [2], e_tf [2];
  logic [16:0] e_period [2];
  int          m_mp, m_n, m_run;

  // Model: the history since capture; count is its length minus one and the
  // repeat count is the length of its trailing run of equal samples.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      m_mp = (i == 0) ? 65535 : 15;
      e_done[i] = 1'b0;
      if (rst) begin
        mode[i] = M_IDLE; hlen[i] = 0;
        e_period[i] = '0; e_ok[i] = 0; e_zf[i] = 0; e_sf[i] = 0; e_tf[i] = 0;
      end else begin
        case (mode[i])
          M_IDLE, M_DONE, M_FAULT: if (start) begin
            mode[i] = M_CAP;
            e_period[i] = '0; e_ok[i] = 0; e_zf[i] = 0; e_sf[i] = 0; e_tf[i] = 0;
          end
          M_CAP: if (in_valid) begin
            if (state_in == 16'h0) begin
              e_zf[i] = 1; mode[i] = M_FAULT; e_done[i] = 1;
            end else begin
              hist[i][0] = state_in; hlen[i] = 1; mode[i] = M_RUN;
            end
          end
          M_RUN: if (in_valid) begin
            if (hlen[i] < HMAX) hist[i][hlen[i]] = state_in;
            hlen[i] = hlen[i] + 1;
            m_n = hlen[i] - 1;
            m_run = 1;
            for (int k = hlen[i] - 2; k >= 0 && m_run < 4; k--) begin
              if (hist[i][k] != state_in) break;
              m_run++;
            end
            if (state_in == 16'h0) begin
              e_zf[i] = 1; mode[i] = M_FAULT; e_done[i] = 1;
            end else if (m_run >= 4) begin
              e_sf[i] = 1; mode[i] = M_FAULT; e_done[i] = 1;
            end else if (m_run > 1) begin
              // repeat below the limit: keep running
            end else if (state_in == hist[i][0]) begin
              e_period[i] = 17'(m_n); e_ok[i] = (m_n == m_mp); mode[i] = M_DONE; e_done[i] = 1;
            end else if (m_n >= m_mp + 1) begin
              e_tf[i] = 1; mode[i] = M_FAULT; e_done[i] = 1;
            end
          end
          default: mode[i] = M_IDLE;
        endcase
      end
      e_busy[i] = (mode[i] == M_CAP) || (mode[i] == M_RUN);
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        logic [22:0] act, exp;
        act = {busy_o[i], done_o[i], period_o[i], ok_o[i], zf_o[i], sf_o[i], tf_o[i]};
        exp = {e_busy[i], e_done[i], e_period[i], e_ok[i], e_zf[i], e_sf[i], e_tf[i]};
        total++;
        if (act !== exp) begin
          bad++;
          $display("FAIL model_cmp dut%0d t=%0t got=%h expected=%h", i, $time, act, exp);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic st, input logic v, input logic [15:0] s);
    start = st; in_valid = v; state_in = s;
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 16'h0);
    cyc(0, 0, 16'h0);
    rst = 1'b0;
  endtask

  logic [15:0] lf;
  logic        fb;
  int          v;

  initial begin
    rst = 1'b1; start = 0; in_valid = 0; state_in = '0;
    cyc(0, 0, 16'h0);
    armed = 1'b1;
    cyc(0, 0, 16'h0);
    chk("reset_busy", 32'(busy_o[0]), 0);
    chk("reset_period", 32'(period_o[0]), 0);
    chk("reset_flags", {29'd0, zf_o[0], sf_o[0], tf_o[0]}, 0);

    // start in the first cycle after reset release
    rst = 1'b0;
    cyc(1, 0, 16'h0);
    chk("first_start_busy", 32'(busy_o[0]), 1);

    // simple period 3
    cyc(0, 1, 16'h0001); cyc(0, 1, 16'h0002); cyc(0, 1, 16'h0003); cyc(0, 1, 16'h0001);
    chk("p3_done", 32'(done_o[0]), 1);
    chk("p3_period", 32'(period_o[0]), 3);
    chk("p3_ok", 32'(ok_o[0]), 0);
    cyc(0, 0, 16'h0);
    chk("p3_done_pulse", 32'(done_o[0]), 0);

    // same with gaps and a start pulse while busy
    cyc(1, 0, 16'h0);
    cyc(0, 1, 16'h0001); cyc(0, 0, 16'h0007); cyc(0, 1, 16'h0002);
    cyc(1, 0, 16'h0000); cyc(0, 0, 16'h0001); cyc(0, 1, 16'h0003); cyc(0, 1, 16'h0001);
    chk("gap_period", 32'(period_o[0]), 3);
    chk("gap_done", 32'(done_o[0]), 1);

    // zero fault, then clean restart
    cyc(1, 0, 16'h0);
    cyc(0, 1, 16'h1234); cyc(0, 1, 16'h5678); cyc(0, 1, 16'h0000);
    chk("zero_flag", 32'(zf_o[0]), 1);
    chk("zero_done", 32'(done_o[0]), 1);
    chk("zero_period", 32'(period_o[0]), 0);
    cyc(1, 0, 16'h0);
    chk("restart_busy", 32'(busy_o[0]), 1);
    chk("restart_flags", {29'd0, zf_o[0], sf_o[0], tf_o[0]}, 0);

    // stuck: three copies keep running, the fourth faults
    cyc(0, 1, 16'h1234); cyc(0, 1, 16'h1234); cyc(0, 1, 16'h1234);
    chk("stuck3_busy", 32'(busy_o[0]), 1);
    chk("stuck3_flag", 32'(sf_o[0]), 0);
    cyc(0, 1, 16'h1234);
    chk("stuck4_flag", 32'(sf_o[0]), 1);
    chk("stuck4_done", 32'(done_o[0]), 1);

    // timeout on the MAX_PERIOD=15 instance at count 16
    cyc(1, 0, 16'h0);
    cyc(0, 1, 16'h0001);
    for (int k = 1; k <= 15; k++) cyc(0, 1, (k % 2 == 1) ? 16'h0005 : 16'h0006);
    chk("to15_busy", 32'(busy_o[1]), 1);
    chk("to15_flag", 32'(tf_o[1]), 0);
    cyc(0, 1, 16'h0006);
    chk("to16_flag", 32'(tf_o[1]), 1);
    chk("to16_done", 32'(done_o[1]), 1);
    chk("to16_a_busy", 32'(busy_o[0]), 1);

    // reset mid-run on the default instance
    rst = 1'b1;
    cyc(0, 1, 16'h0009);
    rst = 1'b0;
    chk("midrun_rst", {busy_o[0], done_o[0], period_o[0], ok_o[0], zf_o[0], sf_o[0], tf_o[0]}, 0);

    // randomized streams over a small alphabet to provoke repeats, matches and zeros
    for (int r = 0; r < 12; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        v = $urandom_range(0, 15);
        if ($urandom_range(0, 99) == 0) rst = 1'b1;
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            (v == 0) ? 16'h0 : 16'(v % 4 + 1));
        rst = 1'b0;
      end
    end

    // maximal 16-bit LFSR from 0xACE1
    do_reset();
    cyc(1, 0, 16'h0);
    lf = 16'hACE1;
    cyc(0, 1, lf);
    for (int k = 0; k < 65535; k++) begin
      fb = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
      lf = {fb, lf[15:1]};
      cyc(0, 1, lf);
    end
    chk("lfsr_done", 32'(done_o[0]), 1);
    chk("lfsr_period", 32'(period_o[0]), 65535);
    chk("lfsr_ok", 32'(ok_o[0]), 1);
    chk("lfsr_flags", {29'd0, zf_o[0], sf_o[0], tf_o[0]}, 0);
    cyc(0, 0, 16'h0);
    chk("lfsr_busy_after", 32'(busy_o[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
